// File: rtl/fft16_pkg.sv
// Shared constants and types for the 16-point FFT datapath.
// Used by the output reorder buffer and its register banks.
package fft16_pkg;

    localparam int CW    = 17;
    localparam int SW    = 2 * CW;
    localparam int WW    = 8 * CW;
    localparam int NPT   = 16;
    localparam int RADIX = 4;

    typedef logic [SW-1:0] sample_t;
    typedef logic [WW-1:0] word_t;

    // Lane j of a butterfly word carries bin k+4j as {Re, Im}.
    function automatic sample_t lane_slice(input word_t word, input int lane);
        return word[SW*lane +: SW];
    endfunction

endpackage

// File: rtl/fft16_bank.sv
// 16-entry sample bank: one 4-lane write port (lane j -> entry base+4j)
// and one combinational read port.
module fft16_bank
    import fft16_pkg::*;
#(
    parameter int BANK_CW = fft16_pkg::CW
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [1:0]           wr_base,
    input  logic [8*BANK_CW-1:0] wr_data,
    input  logic [3:0]           rd_addr,
    output logic [2*BANK_CW-1:0] rd_data
);

    localparam int BSW = 2 * BANK_CW;

    logic [BSW-1:0] mem_q [NPT];
    logic [BSW-1:0] mem_d [NPT];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            for (int j = 0; j < RADIX; j++) begin
                mem_d[{j[1:0], wr_base}] = wr_data[BSW*j +: BSW];
            end
        end
    end

    // NOTE: storage is deliberately not reset; the full flags gate every read,
    // so stale contents can never reach the output.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fft16_out_reorder.sv
// Ping-pong reorder buffer: takes four butterfly-order words per frame and
// streams the 16 bins out in natural order, one sample per handshake.
module fft16_out_reorder
    import fft16_pkg::*;
#(
    parameter int CW = fft16_pkg::CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [8*CW-1:0] s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [2*CW-1:0] m_data,
    output logic [3:0]      m_index,
    output logic            m_last
);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [1:0] wr_cnt_q, wr_cnt_d;
    logic       rd_bank_q, rd_bank_d;
    logic [3:0] rd_idx_q, rd_idx_d;

    logic            accept;
    logic            handshake;
    logic [1:0]      bank_we;
    logic [2*CW-1:0] bank_rd_data [2];

    assign bank_we = {accept && wr_bank_q, accept && !wr_bank_q};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft16_bank #(.BANK_CW(CW)) u_bank (
            .clk     (clk),
            .we      (bank_we[b]),
            .wr_base (wr_cnt_q),
            .wr_data (s_data),
            .rd_addr (rd_idx_q),
            .rd_data (bank_rd_data[b])
        );
    end

    // NOTE: every signal assigned in a combinational block gets a default at the
    // top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        s_ready   = !rst && !full_q[wr_bank_q];
        m_valid   = full_q[rd_bank_q];
        m_index   = rd_idx_q;
        m_last    = m_valid && (rd_idx_q == 4'(NPT - 1));
        m_data    = m_valid ? bank_rd_data[rd_bank_q] : '0;
        accept    = s_valid && s_ready;
        handshake = m_valid && m_ready;
    end

    // Write and read sides never touch the same full flag in one cycle: a full
    // bank blocks its writer until the reader has cleared it.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;

        if (accept) begin
            wr_cnt_d = wr_cnt_q + 2'd1;
            if (wr_cnt_q == 2'(RADIX - 1)) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        if (handshake) begin
            rd_idx_d = rd_idx_q + 4'd1;
            if (m_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

endmodule

// File: doc/fft16_out_reorder.md
# fft16_out_reorder

Output reorder buffer behind the radix-4 `butterfly` in the 16-point FFT datapath. It accepts the four 136-bit stage-2 result words of one frame in butterfly order (bins k, k+4, k+8, k+12 for k = 0..3). It emits the 16 bins one complex sample per cycle in natural order 0..15. Storage is a ping-pong pair of banks, so one frame is written while the previous frame drains. Both sides use valid/ready handshakes.

## Interface
- `CW`, default 17: component width. Layout is 1 sign bit, 8 integer bits, 8 fraction bits, two's complement. A sample is 2·CW bits; an input word is 8·CW bits.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: buffer can take an input word.
- `s_data` in 8·CW: lane j occupies bits [2CW·j+2CW−1 : 2CW·j]. Lane j carries bin k+4j. Within each lane, Re is the upper CW bits and Im the lower CW bits.
- `m_valid` out 1: output sample valid.
- `m_ready` in 1: downstream accepts the sample.
- `m_data` out 2·CW: {Re, Im} of the current bin.
- `m_index` out 4: bin number of `m_data`.
- `m_last` out 1: high with bin 15.

## Operation
- State per bank b∈{0,1}:
  - `full[b]`, a flag.
  - `wr_bank` and a 2-bit `wr_cnt` (k of the next input word).
  - `rd_bank` and a 4-bit `rd_idx`.
- Write side:
  - `s_ready` = !rst && !full[wr_bank].
  - An accept (`s_valid && s_ready`) stores lane j of the word into bank[wr_bank][wr_cnt + 4j] for all four lanes in one cycle, then increments `wr_cnt`.
  - On the accept with `wr_cnt`==3: set full[wr_bank], toggle `wr_bank`, and wrap `wr_cnt` to 0.
- Read side:
  - `m_valid` = full[rd_bank].
  - `m_data` = bank[rd_bank][rd_idx] when `m_valid`, else 0.
  - `m_index` = `rd_idx`.
  - `m_last` = `m_valid` && `rd_idx`==15.
  - A handshake increments `rd_idx`.
  - On the handshake with `m_last`: clear full[rd_bank], toggle `rd_bank`, and wrap `rd_idx` to 0.
- Simultaneous events:
  - A set and a clear of the same bank in the same cycle cannot occur, because the write side is blocked on a full bank.
  - The write side and read side operating on different banks in the same cycle are independent.
- Data is passed through unchanged, with no arithmetic, rounding or saturation.
- No frame boundary input exists. Frame alignment comes purely from counting four accepted words after reset.

## Timing
- Reset values:
  - `full`=00, `wr_bank`=0, `rd_bank`=0, `wr_cnt`=0, `rd_idx`=0.
  - Outputs: `s_ready`=0 while `rst` is high and 1 in the first cycle after. `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0.
  - Bank storage is not reset.
- Latency: if the 4th word of a frame is accepted at edge N, bin 0 is presented with `m_valid`=1 in the cycle after edge N.
- A bank freed by the `m_last` handshake at edge M can accept a write in the cycle after M, not in the same cycle.
- Sustained throughput is 4 input words per 16 output cycles. The input stalls (`s_ready`=0) whenever both banks are full.
- Output hold: while `m_valid`=1 and `m_ready`=0, `m_data`, `m_index` and `m_last` stay stable.
- Reset mid-operation (frame partly written or partly read) discards all frames. The state matches the post-reset state on the next cycle.

## Structure
- Shared package `fft16_pkg` holds:
  - `CW`
  - the sample and word width constants
  - `NPT`=16 and `RADIX`=4
  - the 34-bit sample type
  - the lane slice function
- One natural sub-module, `fft16_bank` (16×2CW register bank). It has a 4-lane write port with a 2-bit base address and 1 combinational read port. It is instantiated twice.

## Test plan
- Single frame: write words k=0..3, where lane j of word k = {Re=k+4j, Im=−(k+4j)}, with `m_ready`=1 throughout. Expect bins 0..15 in order, each with its own Re/Im and `m_index`, `m_last` only on 15, and the first `m_valid` in the cycle after the 4th accept.
- Back-to-back: write 3 frames with `s_valid` held at 1 and `m_ready`=0 at first. Expect `s_ready` to drop after 8 words, then release 1 cycle after the first `m_last` handshake. All 48 samples come out in order with no loss.
- Output backpressure: toggle `m_ready` pseudo-randomly. Expect `m_data`/`m_index` stable while stalled, and exactly 16 handshakes per frame.
- Sign/extremes: load lanes with 0x10000 (−256.0) and 0x0FFFF. Expect the bit patterns reproduced unchanged at bins 0..15.
- Reset mid-frame: assert `rst` for 1 cycle after 2 words, or mid-drain at bin 7. Expect all outputs 0 on the next cycle, `s_ready`=1 after that, and a following full frame emitted starting at bin 0.
